// File: rtl/nibble_serial_sub_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_sub_ctrl_pkg
// Description : Shared constants, controller state type and index-width
//               helper for the nibble-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_sub_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_sub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_sub_ctrl_if
// Description : Operand/result handshake bundle for the nibble-serial
//               subtractor. master = requester/consumer, slave = engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_sub_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int WIDTH = 4 * NIBBLES;

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin_in;
    logic             in_ready;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff_out;
    logic             bout_out;
    logic             zero_out;

    modport master (
        output start, a_in, b_in, bin_in, out_ready,
        input  in_ready, busy, out_valid, diff_out, bout_out, zero_out
    );

    modport slave (
        input  start, a_in, b_in, bin_in, out_ready,
        output in_ready, busy, out_valid, diff_out, bout_out, zero_out
    );

endinterface
`default_nettype wire

// File: rtl/subtractor_4bit.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_4bit
// Description : Combinational 4-bit subtractor with borrow-in/borrow-out.
//               diff = a - b - bin (mod 16); bout = 1 when a < b + bin.
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);
    logic [4:0] full;

    // A 5-bit difference puts the underflow into bit 4.
    always_comb begin
        full = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
        diff = full[3:0];
        bout = full[4];
    end

endmodule
`default_nettype wire

// File: rtl/nibble_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_sub_ctrl
// Description : Wide subtraction by reusing one 4-bit subtractor, one nibble
//               per cycle LSB first, with the borrow carried in a register.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_sub_ctrl
    import nibble_serial_sub_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_serial_sub_ctrl_if.slave  bus
);
    localparam int               IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                           state;
    state_t                           state_next;
    logic [IDX_W-1:0]                 idx;
    logic                             borrow;
    logic                             zero_reg;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] a_reg;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] b_reg;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] acc;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] acc_next;
    logic [NIBBLE_W-1:0]              sub_diff;
    logic                             sub_bout;
    logic                             in_ready;
    logic                             busy;
    logic                             out_valid;
    logic                             accept;
    logic                             last_step;

    subtractor_4bit u_sub (
        .a    (a_reg[idx]),
        .b    (b_reg[idx]),
        .bin  (borrow),
        .diff (sub_diff),
        .bout (sub_bout)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept    = in_ready & bus.start;
    assign last_step = busy & (idx == LAST_IDX);

    // Accumulator with the current nibble slot overwritten by the subtractor.
    always_comb begin
        acc_next      = acc;
        acc_next[idx] = sub_diff;
    end

    // Operand capture, per-nibble accumulation, borrow chain and index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            borrow   <= 1'b0;
            idx      <= '0;
            zero_reg <= 1'b0;
        end else if (accept) begin
            a_reg  <= bus.a_in;
            b_reg  <= bus.b_in;
            borrow <= bus.bin_in;
            acc    <= '0;
            idx    <= '0;
        end else if (busy) begin
            acc    <= acc_next;
            borrow <= sub_bout;
            // Parking the index at zero keeps it from wrapping past the top.
            idx    <= last_step ? '0 : idx + IDX_W'(1);
            if (last_step) zero_reg <= (acc_next == '0);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.diff_out  = acc;
    assign bus.bout_out  = borrow;
    assign bus.zero_out  = zero_reg;

endmodule
`default_nettype wire

// File: doc/nibble_serial_sub_ctrl.md
Name: nibble_serial_sub_ctrl

Overview:
Sequencer that performs a wide subtraction (4*NIBBLES bits) by time-multiplexing one subtractor_4bit instance, one nibble per cycle, LSB nibble first, carrying the borrow between cycles in a register. Operands are accepted with a start/in_ready handshake. The result is returned with an out_valid/out_ready handshake. Intended as the arithmetic engine behind wider-word ALU ops, reusing the existing 4-bit datapath.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width = 4*NIBBLES (min 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request to begin; accepted when start && in_ready
a_in  input  4*NIBBLES  minuend, sampled on accept
b_in  input  4*NIBBLES  subtrahend, sampled on accept
bin_in  input  1  initial borrow-in, sampled on accept
in_ready  output  1  high only in IDLE
busy  output  1  high in RUN
out_valid  output  1  result valid, high in HOLD
out_ready  input  1  consumer accepts result when out_valid && out_ready
diff_out  output  4*NIBBLES  result = a - b - bin mod 2^(4*NIBBLES)
bout_out  output  1  final borrow; 1 iff a < b + bin
zero_out  output  1  diff_out == 0

Behaviour:
- States: IDLE, RUN, HOLD.
- Reset (rst_n low at a rising edge; the only reset mechanism):
  - state=IDLE, nibble index=0, borrow reg=0, operand regs=0.
  - diff_out=0, bout_out=0, zero_out=0, out_valid=0, busy=0.
  - in_ready=1 from the first cycle after reset.
  - Reset during RUN or HOLD aborts the operation; the partial result is discarded.
- IDLE:
  - in_ready=1.
  - On start: latch a_in, b_in, bin_in into operand regs and borrow reg; clear the diff accumulator; set index=0; go to RUN.
  - Without start: remain in IDLE.
- RUN (busy=1, in_ready=0):
  - Subtractor inputs are operand nibble [index], with bin = borrow reg.
  - At each edge, write diff nibble [index] into the accumulator, load borrow reg with bout, and increment index.
  - After the edge that processes index NIBBLES-1, go to HOLD.
  - The subtractor is purely combinational; every RUN cycle completes one nibble.
- Latency: out_valid rises exactly NIBBLES cycles after the accept edge (NIBBLES=4: accept at edge 0, out_valid=1 after edge 4).
- HOLD (out_valid=1):
  - diff_out, bout_out (= borrow reg) and zero_out are stable.
  - On out_ready, go to IDLE at the next edge; out_valid drops and in_ready rises together.
  - There is no accept in the same cycle as the result handshake; minimum issue interval is NIBBLES+2 cycles when out_ready is tied high.
- start while in_ready=0 is ignored; it is not queued.
- Input changes after accept have no effect on the operation in progress.
- diff_out, bout_out and zero_out hold their last value in IDLE. Consumers qualify them only with out_valid.
- out_ready outside HOLD is ignored.
- Index counter width is clog2(NIBBLES) (min 1). The index never wraps while in RUN.
- Arithmetic: unsigned modular result. bout_out is the unsigned underflow indicator; signed overflow is not reported.

Decomposition:
- Shared package (sub_pkg):
  - NIBBLE_W=4
  - state enum {IDLE, RUN, HOLD}
  - function returning clog2 for index width.
- Sub-module: the existing subtractor_4bit, instantiated once (a, b, bin, diff, bout). No other sub-modules.
- Controller FSM, index counter, borrow reg and accumulator are all in nibble_serial_sub_ctrl.

Test Plan:
All scenarios use NIBBLES=4.
- start, a=0x1234, b=0x0235, bin=0 -> after 4 cycles out_valid=1, diff=0x0FFF, bout=0, zero=0; busy=1 for exactly 4 cycles.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. Then a=0xA5A5, b=0xA5A5, bin=1 -> diff=0xFFFF, bout=1.
- a=0xA5A5, b=0xA5A5, bin=0 -> diff=0x0000, bout=0, zero=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0. A start pulse with new operands during HOLD is ignored. Raising out_ready -> in_ready=1 next cycle.
- Start pulsed again during RUN with different operands -> ignored; result matches the first operands.
- rst_n=0 for one edge at the 2nd RUN cycle -> next cycle state IDLE, out_valid=0, diff=0, in_ready=1. A new op 0x8000-0x0001 -> 0x7FFF, bout=0.
